// File: rtl/matrix_coprocessor_pkg.sv
// Shared definitions for the sequential matrix coprocessor: op codes, FSM
// state encoding, packed-matrix element indexing and element range handling
// (overflow detection plus wrap/clamp).
package matrix_coprocessor_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MMUL  = 3'b010;
    localparam logic [2:0] OP_SMUL  = 3'b011;
    localparam logic [2:0] OP_TRANS = 3'b101;
    localparam logic [2:0] OP_NEG   = 3'b110;

    // Widest element supported and the matching full-precision intermediate.
    localparam int MAX_ELEM_W = 16;
    localparam int ACC_MAX_W  = 2 * MAX_ELEM_W + 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Linear element index of (r,c) inside a packed N_MAX x N_MAX bus.
    function automatic int idx(input int r, input int c, input int n_max);
        return r * n_max + c;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return !((op == 3'b100) || (op == 3'b111));
    endfunction

    function automatic logic signed [ACC_MAX_W-1:0] elem_max(input int elem_w);
        return (ACC_MAX_W'(1) <<< (elem_w - 1)) - ACC_MAX_W'(1);
    endfunction

    function automatic logic in_range(input logic signed [ACC_MAX_W-1:0] v,
                                      input int elem_w);
        logic signed [ACC_MAX_W-1:0] hi;
        logic signed [ACC_MAX_W-1:0] lo;
        hi = elem_max(elem_w);
        lo = -hi - ACC_MAX_W'(1);
        return (v <= hi) && (v >= lo);
    endfunction

    // Returns the value to store; the caller keeps the low elem_w bits, which
    // for the wrap policy is exactly two's-complement wrap.
    function automatic logic signed [ACC_MAX_W-1:0] fit_value(
        input logic signed [ACC_MAX_W-1:0] v,
        input int                          elem_w,
        input bit                          sat
    );
        logic signed [ACC_MAX_W-1:0] hi;
        logic signed [ACC_MAX_W-1:0] lo;
        hi = elem_max(elem_w);
        lo = -hi - ACC_MAX_W'(1);
        if (sat && (v > hi)) return hi;
        if (sat && (v < lo)) return lo;
        return v;
    endfunction

endpackage

// File: rtl/matrix_elem_alu.sv
// Combinational single-element ALU. Computes result element (r,c) for the
// given op from the latched operand matrices, at full precision, then applies
// the wrap or saturate policy.
// Ports: op, r, c, n (active dimension), matrix_a, matrix_b, scalar in;
//        elem (stored value) and elem_ovf (intermediate out of range) out.
module matrix_elem_alu
    import matrix_coprocessor_pkg::*;
#(
    parameter int ELEM_W   = 8,
    parameter int N_MAX    = 5,
    parameter int SATURATE = 0,
    parameter int IDX_W    = $clog2(N_MAX + 1)
) (
    input  logic        [2:0]                      op,
    input  logic        [IDX_W-1:0]                r,
    input  logic        [IDX_W-1:0]                c,
    input  logic        [IDX_W-1:0]                n,
    input  logic        [N_MAX*N_MAX*ELEM_W-1:0]   matrix_a,
    input  logic        [N_MAX*N_MAX*ELEM_W-1:0]   matrix_b,
    input  logic signed [ELEM_W-1:0]               scalar,
    output logic signed [ELEM_W-1:0]               elem,
    output logic                                   elem_ovf
);

    localparam int ACC_W = 2 * ELEM_W + 3;

    logic signed [ELEM_W-1:0]    a_m [N_MAX][N_MAX];
    logic signed [ELEM_W-1:0]    b_m [N_MAX][N_MAX];
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_MAX_W-1:0] acc_x;

    always_comb begin
        for (int rr = 0; rr < N_MAX; rr++) begin
            for (int cc = 0; cc < N_MAX; cc++) begin
                a_m[rr][cc] = matrix_a[idx(rr, cc, N_MAX)*ELEM_W +: ELEM_W];
                b_m[rr][cc] = matrix_b[idx(rr, cc, N_MAX)*ELEM_W +: ELEM_W];
            end
        end
    end

    always_comb begin
        acc = '0;
        case (op)
            OP_ADD:   acc = ACC_W'(a_m[r][c]) + ACC_W'(b_m[r][c]);
            OP_SUB:   acc = ACC_W'(a_m[r][c]) - ACC_W'(b_m[r][c]);
            OP_NEG:   acc = -ACC_W'(a_m[r][c]);
            OP_SMUL:  acc = ACC_W'(a_m[r][c]) * ACC_W'(scalar);
            OP_TRANS: acc = ACC_W'(a_m[c][r]);
            OP_MMUL: begin
                // Terms beyond the active dimension are skipped so stale
                // operand data outside the n x n block never contributes.
                for (int k = 0; k < N_MAX; k++) begin
                    if (IDX_W'(k) < n) begin
                        acc = acc + ACC_W'(a_m[r][k]) * ACC_W'(b_m[k][c]);
                    end
                end
            end
            default:  acc = '0;
        endcase
    end

    assign acc_x    = ACC_MAX_W'(acc);
    assign elem     = ELEM_W'(fit_value(acc_x, ELEM_W, bit'(SATURATE != 0)));
    assign elem_ovf = !in_range(acc_x, ELEM_W);

endmodule

// File: rtl/matrix_coprocessor_seq.sv
// Sequential matrix coprocessor. A start strobe in IDLE latches the operands
// and op; RUN then produces one result element per clock in row scan order;
// DONE pulses done for one cycle. result/overflow/error hold until the next
// accepted command.
// Ports: clk, reset (sync, active-high), start, op_code, matrix_size,
//        matrix_a, matrix_b, scalar in; busy, done, overflow, error, result out.
module matrix_coprocessor_seq
    import matrix_coprocessor_pkg::*;
#(
    parameter int ELEM_W   = 8,
    parameter int N_MAX    = 5,
    parameter int SATURATE = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic        [2:0]                 op_code,
    input  logic        [1:0]                 matrix_size,
    input  logic        [N_MAX*N_MAX*ELEM_W-1:0] matrix_a,
    input  logic        [N_MAX*N_MAX*ELEM_W-1:0] matrix_b,
    input  logic signed [ELEM_W-1:0]          scalar,
    output logic                              busy,
    output logic                              done,
    output logic                              overflow,
    output logic                              error,
    output logic        [N_MAX*N_MAX*ELEM_W-1:0] result
);

    localparam int IDX_W = $clog2(N_MAX + 1);
    localparam int MAT_W = N_MAX * N_MAX * ELEM_W;

    state_t                   state_q, state_nx;
    logic        [2:0]        op_q;
    logic        [IDX_W-1:0]  n_q, n_start;
    logic        [MAT_W-1:0]  a_q, b_q;
    logic signed [ELEM_W-1:0] scalar_q;
    logic        [IDX_W-1:0]  r_q, c_q;
    logic        [MAT_W-1:0]  result_q;
    logic                     ovf_q, err_q;
    logic signed [ELEM_W-1:0] elem;
    logic                     elem_ovf;
    logic                     last_elem;

    always_comb begin
        if (int'(matrix_size) + 2 > N_MAX) n_start = IDX_W'(N_MAX);
        else                               n_start = IDX_W'(int'(matrix_size) + 2);
    end

    assign last_elem = (r_q == n_q - IDX_W'(1)) && (c_q == n_q - IDX_W'(1));

    matrix_elem_alu #(
        .ELEM_W   (ELEM_W),
        .N_MAX    (N_MAX),
        .SATURATE (SATURATE),
        .IDX_W    (IDX_W)
    ) u_alu (
        .op       (op_q),
        .r        (r_q),
        .c        (c_q),
        .n        (n_q),
        .matrix_a (a_q),
        .matrix_b (b_q),
        .scalar   (scalar_q),
        .elem     (elem),
        .elem_ovf (elem_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_nx = op_legal(op_code) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_elem) state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            r_q      <= '0;
            c_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q     <= op_code;
                        n_q      <= n_start;
                        a_q      <= matrix_a;
                        b_q      <= matrix_b;
                        scalar_q <= scalar;
                        result_q <= '0;
                        ovf_q    <= 1'b0;
                        err_q    <= !op_legal(op_code);
                        r_q      <= '0;
                        c_q      <= '0;
                    end
                end
                ST_RUN: begin
                    for (int rr = 0; rr < N_MAX; rr++) begin
                        for (int cc = 0; cc < N_MAX; cc++) begin
                            if ((IDX_W'(rr) == r_q) && (IDX_W'(cc) == c_q)) begin
                                result_q[idx(rr, cc, N_MAX)*ELEM_W +: ELEM_W] <= elem;
                            end
                        end
                    end
                    ovf_q <= ovf_q | elem_ovf;
                    if (c_q == n_q - IDX_W'(1)) begin
                        c_q <= '0;
                        r_q <= r_q + IDX_W'(1);
                    end else begin
                        c_q <= c_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result   = result_q;
    assign overflow = ovf_q;
    assign error    = err_q;

endmodule

// File: tb/tb_matrix_coprocessor_seq.sv
// Directed bench for matrix_coprocessor_seq. Two instances share all inputs:
// one wraps, one saturates, so each vector checks both range policies.
module tb_matrix_coprocessor_seq;
    import matrix_coprocessor_pkg::*;

    localparam int RES_W = 5 * 5 * 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [2:0]        op_code;
    logic [1:0]        matrix_size;
    logic [RES_W-1:0]  matrix_a, matrix_b;
    logic signed [7:0] scalar;
    logic              busy_w, done_w, ovf_w, err_w;
    logic              busy_s, done_s, ovf_s, err_s;
    logic [RES_W-1:0]  result_w, result_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matrix_coprocessor_seq #(.ELEM_W(8), .N_MAX(5), .SATURATE(0)) dut (
        .clk(clk), .reset(reset), .start(start), .op_code(op_code),
        .matrix_size(matrix_size), .matrix_a(matrix_a), .matrix_b(matrix_b),
        .scalar(scalar), .busy(busy_w), .done(done_w), .overflow(ovf_w),
        .error(err_w), .result(result_w)
    );

    matrix_coprocessor_seq #(.ELEM_W(8), .N_MAX(5), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .op_code(op_code),
        .matrix_size(matrix_size), .matrix_a(matrix_a), .matrix_b(matrix_b),
        .scalar(scalar), .busy(busy_s), .done(done_s), .overflow(ovf_s),
        .error(err_s), .result(result_s)
    );

    typedef struct {
        logic [2:0]       op;
        logic [1:0]       size;
        logic [RES_W-1:0] a;
        logic [RES_W-1:0] b;
        logic [7:0]       scalar;
        logic [RES_W-1:0] exp_w;
        logic [RES_W-1:0] exp_s;
        logic             exp_ovf;
        logic             exp_err;
        int               lat;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [RES_W-1:0] put(input logic [RES_W-1:0] m,
                                             input int r, input int c, input int v);
        logic [RES_W-1:0] t;
        t = m;
        t[(r*5+c)*8 +: 8] = 8'(v);
        return t;
    endfunction

    function automatic logic [RES_W-1:0] mat2(input int a00, input int a01,
                                              input int a10, input int a11);
        logic [RES_W-1:0] t;
        t = '0;
        t = put(t, 0, 0, a00);
        t = put(t, 0, 1, a01);
        t = put(t, 1, 0, a10);
        t = put(t, 1, 1, a11);
        return t;
    endfunction

    function automatic logic [RES_W-1:0] block(input int n, input int v);
        logic [RES_W-1:0] t;
        t = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                t = put(t, r, c, v);
        return t;
    endfunction

    task automatic check_mat(input string name, input logic [RES_W-1:0] act,
                             input logic [RES_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag, input int glitch_at,
                           input bit start_in_done);
        int cycles;
        bit seen;
        bit busy_bad;
        @(negedge clk);
        op_code = v.op; matrix_size = v.size; matrix_a = v.a; matrix_b = v.b;
        scalar = v.scalar; start = 1'b1;
        cycles = 0; seen = 1'b0; busy_bad = 1'b0;
        while (cycles < 60 && !seen) begin
            @(posedge clk); #1;
            cycles++;
            if (cycles == 1) begin
                // Operands must already be latched: scramble the inputs.
                matrix_a = ~matrix_a; matrix_b = ~matrix_b; scalar = ~scalar;
                op_code = OP_MMUL; matrix_size = 2'b11;
            end
            start = (cycles == glitch_at);
            if (busy_w !== (cycles < v.lat)) busy_bad = 1'b1;
            seen = done_w;
        end
        start = 1'b0;
        check_int({tag, " latency"}, cycles, v.lat);
        check_int({tag, " busy"}, int'(busy_bad), 0);
        check_int({tag, " done_sat"}, int'(done_s), 1);
        check_mat({tag, " result_wrap"}, result_w, v.exp_w);
        check_mat({tag, " result_sat"}, result_s, v.exp_s);
        check_int({tag, " overflow_wrap"}, int'(ovf_w), int'(v.exp_ovf));
        check_int({tag, " overflow_sat"}, int'(ovf_s), int'(v.exp_ovf));
        check_int({tag, " error"}, int'(err_w), int'(v.exp_err));
        if (start_in_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_int({tag, " done_pulse"}, int'(done_w), 0);
        check_int({tag, " idle_after"}, int'(busy_w), 0);
        check_mat({tag, " result_hold"}, result_w, v.exp_w);
    endtask

    initial begin
        logic [RES_W-1:0] t;

        // add 2x2
        vecs[0] = '{OP_ADD, 2'd0, mat2(1,2,3,4), mat2(5,6,7,8), 8'd0,
                    mat2(6,8,10,12), mat2(6,8,10,12), 1'b0, 1'b0, 5};
        // matrix mult 3x3, identity * (1..9)
        t = '0;
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) t = put(t, r, c, r*3+c+1);
        vecs[1] = '{OP_MMUL, 2'd1, put(put(put(RES_W'(0),0,0,1),1,1,1),2,2,1), t, 8'd0,
                    t, t, 1'b0, 1'b0, 10};
        // scalar mult 2x2, a all 100 everywhere, scalar 2
        vecs[2] = '{OP_SMUL, 2'd0, block(5, 100), '0, 8'd2,
                    block(2, -56), block(2, 127), 1'b1, 1'b0, 5};
        // opposite 5x5, a(0,0) = -128
        vecs[3] = '{OP_NEG, 2'd3, put(block(5, 1), 0, 0, -128), '0, 8'd0,
                    put(block(5, -1), 0, 0, -128), put(block(5, -1), 0, 0, 127),
                    1'b1, 1'b0, 26};
        // sub 2x2 with negative overflow at (0,0)
        vecs[4] = '{OP_SUB, 2'd0, mat2(-100,2,3,4), mat2(100,6,7,8), 8'd0,
                    mat2(56,-4,-4,-4), mat2(-128,-4,-4,-4), 1'b1, 1'b0, 5};
        // transpose 3x3
        vecs[5] = '{OP_TRANS, 2'd1, t, block(5, 50), 8'd0, '0, '0, 1'b0, 1'b0, 10};
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++)
            vecs[5].exp_w = put(vecs[5].exp_w, r, c, c*3+r+1);
        vecs[5].exp_s = vecs[5].exp_w;
        // matrix mult 2x2; entries at k=2 must not contribute
        vecs[6] = '{OP_MMUL, 2'd0, put(mat2(1,2,3,4), 0, 2, 9), put(mat2(5,6,7,8), 2, 0, 9),
                    8'd0, mat2(19,22,43,50), mat2(19,22,43,50), 1'b0, 1'b0, 5};
        // illegal op codes
        vecs[7] = '{3'b100, 2'd0, mat2(1,2,3,4), mat2(5,6,7,8), 8'd3,
                    '0, '0, 1'b0, 1'b1, 1};
        vecs[8] = '{3'b111, 2'd3, block(5, 9), block(5, 9), 8'd3,
                    '0, '0, 1'b0, 1'b1, 1};
        // add 4x4 landing exactly on the positive limit
        vecs[9] = '{OP_ADD, 2'd2, block(5, 60), block(5, 67), 8'd0,
                    block(4, 127), block(4, 127), 1'b0, 1'b0, 17};

        reset = 1'b1; start = 1'b0; op_code = '0; matrix_size = '0;
        matrix_a = '0; matrix_b = '0; scalar = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_int("reset busy", int'(busy_w), 0);
        check_int("reset done", int'(done_w), 0);
        check_int("reset overflow", int'(ovf_w), 0);
        check_int("reset error", int'(err_w), 0);
        check_mat("reset result", result_w, '0);

        // v7: start during DONE is ignored; v9: start pulsed mid-RUN is ignored
        for (int i = 0; i < 10; i++)
            run_vec(vecs[i], $sformatf("v%0d", i), (i == 9) ? 3 : 0, (i == 7));

        // reset in the middle of a 4x4 mult that has already overflowed
        @(negedge clk);
        op_code = OP_MMUL; matrix_size = 2'd2;
        matrix_a = block(5, 100); matrix_b = block(5, 100); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_int("midrun busy", int'(busy_w), 1);
        check_int("midrun overflow", int'(ovf_w), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_int("post-reset busy", int'(busy_w), 0);
        check_int("post-reset done", int'(done_w), 0);
        check_int("post-reset overflow", int'(ovf_w), 0);
        check_mat("post-reset result", result_w, '0);
        check_mat("post-reset result_sat", result_s, '0);
        run_vec(vecs[6], "after_reset", 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
